// File: rtl/relu_out_serializer.sv
// relu_out_serializer: buffers 16-bit ReLU results in a FIFO and drains them
// as byte pairs over an 8-bit valid/ready link.
module relu_out_serializer #(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic                     CLKEXT,
    input  logic                     RST_GLO,
    input  logic [15:0]              ReLU_OUT,
    input  logic                     OUT_WR,
    input  logic                     CLR_OVF,
    input  logic                     OUT_READY,
    output logic [7:0]               DATA_OUT,
    output logic                     OUT_VALID,
    output logic                     FIFO_FULL,
    output logic                     FIFO_EMPTY,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
    output logic                     OVF
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [15:0]   head, sr;
    logic          pop, wr_ok, drop;
    logic [AW:0]   level_nxt;

    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return MSB_FIRST ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return MSB_FIRST ? w[7:0] : w[15:8];
    endfunction

    // A pop frees a slot, so a full FIFO still takes a write on the same edge.
    assign head      = mem[rp];
    assign pop       = !FIFO_EMPTY && (state == IDLE || (state == BYTE1 && OUT_READY));
    assign wr_ok     = OUT_WR && (!FIFO_FULL || pop);
    assign drop      = OUT_WR && !wr_ok;
    assign level_nxt = FIFO_LEVEL + (AW+1)'(wr_ok) - (AW+1)'(pop);

    always_ff @(posedge CLKEXT)
        if (wr_ok) mem[wp] <= ReLU_OUT;

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            wp         <= '0;
            rp         <= '0;
            FIFO_LEVEL <= '0;
            FIFO_FULL  <= 1'b0;
            FIFO_EMPTY <= 1'b1;
            OVF        <= 1'b0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            FIFO_LEVEL <= level_nxt;
            FIFO_FULL  <= level_nxt == (AW+1)'(DEPTH);
            FIFO_EMPTY <= level_nxt == '0;
            OVF        <= drop || (OVF && !CLR_OVF);
        end
    end

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            state     <= IDLE;
            sr        <= '0;
            DATA_OUT  <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (pop) begin
                        sr        <= head;
                        DATA_OUT  <= first_byte(head);
                        OUT_VALID <= 1'b1;
                        state     <= BYTE0;
                    end
                BYTE0:
                    if (OUT_READY) begin
                        DATA_OUT <= second_byte(sr);
                        state    <= BYTE1;
                    end
                BYTE1:
                    if (OUT_READY) begin
                        if (pop) begin
                            sr       <= head;
                            DATA_OUT <= first_byte(head);
                            state    <= BYTE0;
                        end else begin
                            OUT_VALID <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_relu_out_serializer.sv
// tb_relu_out_serializer: randomized scoreboard bench for both byte orders,
// checked against a word-queue reference model.
module tb_relu_out_serializer;
    localparam int DEPTH = 4;

    logic        clk = 0, rst = 0, wr = 0, clr = 0, ready = 0;
    logic [15:0] din = '0;
    logic [7:0]  data1, data0;
    logic        v1, v0, full1, full0, empty1, empty0, ovf1, ovf0;
    logic [2:0]  lvl1, lvl0;

    int tests = 0, fails = 0;

    // Reference: words waiting in the FIFO, bytes still owed by the serializer.
    int          q[$];
    int          left = 0;
    bit          movf = 0;
    logic [7:0]  exp1[$], exp0[$];
    bit          m_xfer, m_done, m_pop, m_acc;

    logic [7:0]  pd1, pd0;
    bit          pv = 0, pr = 0;

    always #5 clk = ~clk;

    relu_out_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1)) d1 (
        .CLKEXT(clk), .RST_GLO(rst), .ReLU_OUT(din), .OUT_WR(wr), .CLR_OVF(clr),
        .OUT_READY(ready), .DATA_OUT(data1), .OUT_VALID(v1), .FIFO_FULL(full1),
        .FIFO_EMPTY(empty1), .FIFO_LEVEL(lvl1), .OVF(ovf1));

    relu_out_serializer #(.DEPTH(DEPTH), .MSB_FIRST(0)) d0 (
        .CLKEXT(clk), .RST_GLO(rst), .ReLU_OUT(din), .OUT_WR(wr), .CLR_OVF(clr),
        .OUT_READY(ready), .DATA_OUT(data0), .OUT_VALID(v0), .FIFO_FULL(full0),
        .FIFO_EMPTY(empty0), .FIFO_LEVEL(lvl0), .OVF(ovf0));

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            left = 0;
            movf = 0;
            exp1.delete();
            exp0.delete();
        end else begin
            chk("valid1", v1, left > 0);
            chk("valid0", v0, left > 0);
            chk("level", lvl1, q.size());
            chk("level0", lvl0, q.size());
            chk("full", full1, q.size() == DEPTH);
            chk("empty", empty1, q.size() == 0);
            chk("ovf", ovf1, movf);
            m_xfer = left > 0 && ready;
            m_done = left == 0 || (left == 1 && m_xfer);
            m_pop  = m_done && q.size() > 0;
            m_acc  = wr && (q.size() < DEPTH || m_pop);
            left   = m_pop ? 2 : (m_xfer ? left - 1 : left);
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back(din);
                exp1.push_back(din[15:8]);
                exp1.push_back(din[7:0]);
                exp0.push_back(din[7:0]);
                exp0.push_back(din[15:8]);
            end
            movf = (wr && !m_acc) ? 1'b1 : (clr ? 1'b0 : movf);
        end
    end

    always @(negedge clk) begin
        if (rst) pv = 0;
        else begin
            if (pv && !pr) begin
                chk("hold_data1", data1, pd1);
                chk("hold_data0", data0, pd0);
                chk("hold_valid", v1, 1);
            end
            if (v1 && ready) begin
                if (exp1.size() == 0) chk("spurious_byte", data1, 'hx);
                else chk("byte_msb", data1, exp1.pop_front());
                if (exp0.size() != 0) chk("byte_lsb", data0, exp0.pop_front());
            end
            pv  = v1;
            pr  = ready;
            pd1 = data1;
            pd0 = data0;
        end
    end

    task automatic step(input bit w, input logic [15:0] d, input bit r, input bit c);
        wr = w; din = d; ready = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_data1", data1, 0);
        chk("rst_data0", data0, 0);
        chk("rst_valid", v1, 0);
        chk("rst_level", lvl1, 0);
        chk("rst_empty", empty1, 1);
        chk("rst_full", full1, 0);
        chk("rst_ovf", ovf1, 0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1;
        #1 check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 0;
    endtask

    initial begin
        #1 rst = 1;
        #1 check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 0;

        step(1, 16'h1234, 1, 0);
        chk("lat_valid_k", v1, 0);
        chk("lat_empty_k", empty1, 0);
        step(0, 0, 1, 0);
        chk("lat_valid_k1", v1, 1);
        chk("first_msb", data1, 8'h12);
        chk("first_lsb", data0, 8'h34);
        step(0, 0, 1, 0);
        chk("second_msb", data1, 8'h34);
        chk("second_lsb", data0, 8'h12);
        step(0, 0, 1, 0);
        chk("end_valid", v1, 0);
        chk("end_empty", empty1, 1);

        step(1, 16'hABCD, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        chk("stall_data", data1, 8'hAB);
        chk("stall_valid", v1, 1);
        repeat (3) step(0, 0, 1, 0);

        for (int i = 1; i <= 6; i++) step(1, 16'(i), 0, 0);
        chk("ovf_full", full1, 1);
        chk("ovf_level", lvl1, 4);
        chk("ovf_set", ovf1, 1);
        step(1, 16'h0007, 0, 1);
        chk("ovf_set_wins", ovf1, 1);
        step(0, 0, 0, 1);
        chk("ovf_cleared", ovf1, 0);
        step(0, 0, 1, 0);
        step(1, 16'h0008, 1, 0);
        chk("sim_level", lvl1, 4);
        chk("sim_ovf", ovf1, 0);
        repeat (14) step(0, 0, 1, 0);
        chk("drain_empty", empty1, 1);

        for (int i = 0; i < 4; i++) step(1, 16'h5A00 + 16'(i), 0, 0);
        step(0, 0, 1, 0);
        ready = 0;
        chk("pre_rst_level", lvl1, 3);
        pulse_reset();
        repeat (4) step(0, 0, 1, 0);
        chk("no_stale_valid", v1, 0);

        for (int seg = 0; seg < 6; seg++) begin
            for (int n = 0; n < 400; n++) begin
                step($urandom_range(0, 3) != 0, 16'($urandom),
                     $urandom_range(0, 5) < seg + 1, $urandom_range(0, 15) == 0);
                if ($urandom_range(0, 299) == 0) pulse_reset();
            end
        end

        repeat (30) step(0, 0, 1, 0);
        chk("final_drained", exp1.size(), 0);
        chk("final_empty", empty1, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/relu_out_serializer.md
Name: relu_out_serializer

Overview:
- Consumes 16-bit ReLU_OUT words from the ReLU stage, which writes them with a one-cycle strobe.
- Buffers the words in a small FIFO.
- Sends each word out as two bytes over an 8-bit valid/ready interface toward the external pins.
- Acts as the reader/drain side of the ReLU output register, so results are not lost when the external consumer stalls.

Parameters:
- DEPTH, 4, number of 16-bit FIFO entries. Must be a power of 2 and at least 2.
- MSB_FIRST, 1, byte order. 1 sends [15:8] then [7:0]; 0 sends [7:0] then [15:8].

Ports:
- CLKEXT  in  1  single system clock, rising edge.
- RST_GLO  in  1  asynchronous, active-high reset.
- ReLU_OUT  in  16  word from the ReLU stage.
- OUT_WR  in  1  write strobe; ReLU_OUT is sampled on the CLKEXT edge where OUT_WR=1.
- CLR_OVF  in  1  synchronous clear of OVF.
- OUT_READY  in  1  external consumer ready.
- DATA_OUT  out  8  byte being presented.
- OUT_VALID  out  1  DATA_OUT is valid.
- FIFO_FULL  out  1  FIFO holds DEPTH words.
- FIFO_EMPTY  out  1  FIFO holds 0 words.
- FIFO_LEVEL  out  $clog2(DEPTH)+1  number of stored words; excludes the word in the shift register.
- OVF  out  1  sticky flag: a write was dropped.

Behaviour:
- Clock and reset: one clock (CLKEXT); reset RST_GLO is asynchronous and active-high.
- Reset values:
  - DATA_OUT=0, OUT_VALID=0, OVF=0, FIFO_LEVEL=0.
  - FIFO_EMPTY=1, FIFO_FULL=0.
  - FSM in IDLE; read/write pointers at 0.
- Reset mid-operation aborts immediately: a partially sent word and all buffered words are discarded.
- FIFO write:
  - A write is accepted when OUT_WR=1 and (FIFO_FULL=0 or a pop occurs in the same cycle).
  - If OUT_WR=1, FIFO_FULL=1 and there is no pop, the word is dropped and OVF is set.
- OVF:
  - Cleared by CLR_OVF=1.
  - If a drop and CLR_OVF occur in the same cycle, the set wins (OVF=1).
- Pointers wrap modulo DEPTH. FIFO_LEVEL, FULL and EMPTY are registered and updated on the same edge as the write/pop.
- A simultaneous write and pop leaves FIFO_LEVEL unchanged.
- A pop requires FIFO_EMPTY=0 as registered at the start of the cycle. A word written into an empty FIFO cannot be popped in the same cycle.
- FSM states:
  - IDLE: OUT_VALID=0. If FIFO_EMPTY=0, pop the head into a 16-bit shift register and go to BYTE0.
  - BYTE0: OUT_VALID=1; DATA_OUT = first byte per MSB_FIRST. On OUT_VALID&OUT_READY, go to BYTE1.
  - BYTE1: OUT_VALID=1; DATA_OUT = second byte.
    - On a transfer with FIFO_EMPTY=0: pop the next word and go to BYTE0, giving back-to-back bytes with no bubble.
    - On a transfer with FIFO_EMPTY=1: go to IDLE.
- Handshake rules:
  - While OUT_VALID=1 and OUT_READY=0, DATA_OUT and OUT_VALID hold stable.
  - OUT_VALID never drops without a transfer, except on reset.
  - OUT_READY is ignored when OUT_VALID=0.
- Latency:
  - OUT_WR sampled at edge k into an empty, idle block → FIFO_EMPTY=0 after edge k.
  - The pop happens at edge k+1, so OUT_VALID=1 with the first byte after edge k+1.
- Throughput: 1 byte/cycle with OUT_READY held high, i.e. 1 word per 2 cycles.
  - A writer strobing every cycle will overflow after DEPTH+1 words have been accepted without a drain.
- Capacity: the shift register adds one word of capacity beyond DEPTH.
- Data is unsigned pass-through; there is no arithmetic on ReLU_OUT.

Test Plan:
- Reset, then one write of ReLU_OUT=16'h1234 with OUT_READY=1, MSB_FIRST=1:
  - OUT_VALID rises 2 edges after the strobe.
  - DATA_OUT=8'h12, then 8'h34 on the next cycle.
  - Then OUT_VALID=0 and FIFO_EMPTY=1.
- Same write with MSB_FIRST=0 → DATA_OUT bytes 8'h34 then 8'h12.
- Backpressure: write 16'hABCD; hold OUT_READY=0 for 5 cycles, then raise it:
  - DATA_OUT stays 8'hAB with OUT_VALID=1 throughout the stall.
  - Then 8'hAB and 8'hCD transfer on consecutive cycles.
- Overflow, DEPTH=4, OUT_READY=0: write 6 words 16'h0001..16'h0006 on consecutive cycles:
  - Word 1 moves to the shift register; words 2–5 fill the FIFO (FIFO_FULL=1, FIFO_LEVEL=4).
  - Word 6 is dropped and OVF=1.
  - Raising OUT_READY drains bytes 00,01,00,02,…,00,05 back-to-back.
  - OVF stays 1 until CLR_OVF.
- Simultaneous events:
  - With FIFO full, a write in the same cycle as a BYTE1 pop is accepted; FIFO_LEVEL stays 4 and OVF stays 0.
  - CLR_OVF asserted in the same cycle as a drop leaves OVF=1.
- Reset mid-word: assert RST_GLO while in BYTE1 with 3 words buffered:
  - All outputs return to reset values asynchronously.
  - After release, no stale byte is presented until a new write occurs.
